// File: rtl/sobel_3x3.sv
// -----------------------------------------------------------------------------
// sobel_3x3
// Purpose : Sobel edge detector that follows the 3-line buffer. Each valid
//           pixel shifts one column of three vertically aligned taps into a
//           3x3 window. The block outputs (|Gx|+|Gy|) >> SHIFT, saturated to
//           the pixel width, one output pixel per input pixel. The latency is
//           fixed at three clocks and there is no backpressure. Border pixels
//           whose window is incomplete are forced to zero: these are the first
//           two pixels of each line and every pixel of the first two lines.
// Ports   : clk         pixel clock
//           rst         synchronous active-high reset
//           tap0_i      current line pixel (window bottom row)
//           tap1_i      line n-1 pixel (window middle row)
//           tap2_i      line n-2 pixel (window top row)
//           dv_i        taps valid this cycle
//           line_end    single-cycle end-of-line pulse
//           frame_start single-cycle start-of-frame pulse
//           data_o      edge magnitude
//           dv_o        data_o valid
//           line_end_o  line_end delayed to line up with data_o
// -----------------------------------------------------------------------------
module sobel_3x3 #(
    parameter int COLORDEPTH  = 8,
    parameter int SCREENWIDTH = 1600,
    parameter int SHIFT       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] tap0_i,
    input  logic [COLORDEPTH-1:0] tap1_i,
    input  logic [COLORDEPTH-1:0] tap2_i,
    input  logic                  dv_i,
    input  logic                  line_end,
    input  logic                  frame_start,
    output logic [COLORDEPTH-1:0] data_o,
    output logic                  dv_o,
    output logic                  line_end_o
);

    localparam int CW = $clog2(SCREENWIDTH + 1);
    localparam int GW = COLORDEPTH + 3;   // signed gradient width
    localparam int MW = COLORDEPTH + 4;   // unsigned magnitude width
    localparam logic [COLORDEPTH-1:0] MAXV = '1;

    // ---------------------------------------------------------------- counters
    logic [CW-1:0] r_col_cnt;
    logic [1:0]    r_row_cnt;

    // When line_end coincides with dv_i, the pixel sees the old count (the
    // border flag below reads the registered value) and the count then clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= '0;
        end else if (line_end) begin
            r_col_cnt <= '0;
        end else if (dv_i && (r_col_cnt != CW'(SCREENWIDTH))) begin
            r_col_cnt <= r_col_cnt + 1'b1;
        end
    end

    // frame_start wins over a simultaneous line_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt <= '0;
        end else if (frame_start) begin
            r_row_cnt <= '0;
        end else if (line_end && (r_row_cnt != 2'd2)) begin
            r_row_cnt <= r_row_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------ stage 1: window
    // w_p[r][c]: row 0 = top (tap2), row 2 = bottom (tap0); column 2 = newest.
    logic [2:0][2:0][COLORDEPTH-1:0] w_p;
    logic [2:0][COLORDEPTH-1:0]      w_tap;

    assign w_tap[0] = tap2_i;
    assign w_tap[1] = tap1_i;
    assign w_tap[2] = tap0_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [2:0][COLORDEPTH-1:0] r_p;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p <= '0;
                end else if (dv_i) begin
                    r_p[0] <= r_p[1];
                    r_p[1] <= r_p[2];
                    r_p[2] <= w_tap[gi];
                end
            end
            assign w_p[gi] = r_p;
        end
    endgenerate

    logic r_v1, r_b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_b1 <= 1'b0;
        end else begin
            r_v1 <= dv_i;
            r_b1 <= (r_col_cnt < CW'(2)) || (r_row_cnt < 2'd2);
        end
    end

    // --------------------------------------------------- stage 2: gradients
    // Each weighted sum is at most 4*(2^COLORDEPTH-1), which fits in GW bits.
    // The modular difference is therefore the exact signed gradient.
    logic [GW-1:0] w_gx_r, w_gx_l, w_gy_b, w_gy_t;

    assign w_gx_r = GW'(w_p[0][2]) + (GW'(w_p[1][2]) << 1) + GW'(w_p[2][2]);
    assign w_gx_l = GW'(w_p[0][0]) + (GW'(w_p[1][0]) << 1) + GW'(w_p[2][0]);
    assign w_gy_b = GW'(w_p[2][0]) + (GW'(w_p[2][1]) << 1) + GW'(w_p[2][2]);
    assign w_gy_t = GW'(w_p[0][0]) + (GW'(w_p[0][1]) << 1) + GW'(w_p[0][2]);

    logic signed [GW-1:0] r_gx, r_gy;
    logic                 r_v2, r_b2;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gx <= '0;
            r_gy <= '0;
            r_v2 <= 1'b0;
            r_b2 <= 1'b0;
        end else begin
            r_gx <= w_gx_r - w_gx_l;
            r_gy <= w_gy_b - w_gy_t;
            r_v2 <= r_v1;
            r_b2 <= r_b1;
        end
    end

    // --------------------------------------------------- stage 3: magnitude
    logic [GW-1:0]         w_abs_gx, w_abs_gy;
    logic [MW-1:0]         w_sum, w_m;
    logic [COLORDEPTH-1:0] w_sat;

    assign w_abs_gx = r_gx[GW-1] ? GW'(-r_gx) : GW'(r_gx);
    assign w_abs_gy = r_gy[GW-1] ? GW'(-r_gy) : GW'(r_gy);
    assign w_sum    = MW'(w_abs_gx) + MW'(w_abs_gy);
    assign w_m      = w_sum >> SHIFT;
    assign w_sat    = (w_m > MW'(MAXV)) ? MAXV : w_m[COLORDEPTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
            dv_o   <= 1'b0;
        end else begin
            dv_o <= r_v2;
            if (r_v2) begin
                data_o <= r_b2 ? '0 : w_sat;
            end
        end
    end

    // line_end runs through a bare delay line that ignores dv_i.
    logic [2:0] r_le_pipe;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_le_pipe <= '0;
        end else begin
            r_le_pipe <= {r_le_pipe[1:0], line_end};
        end
    end
    assign line_end_o = r_le_pipe[2];

endmodule

// File: tb/tb_sobel_3x3.sv
// -----------------------------------------------------------------------------
// tb_sobel_3x3
// Randomised and patterned frames drive sobel_3x3. Each input edge is sampled
// by a reference model that tracks the last three valid tap columns and the
// line/row positions. The model pushes the expected edge value for every valid
// pixel into a queue, and an independent monitor pops and compares the queue
// on each dv_o. The monitor also checks latency, data hold between valids,
// line_end_o alignment and the output state during reset.
// -----------------------------------------------------------------------------
module tb_sobel_3x3;

    localparam int CD = 8;
    localparam int SW = 1600;

    logic          clk = 1'b0;
    logic          rst, dv_i, line_end, frame_start;
    logic [CD-1:0] tap0_i, tap1_i, tap2_i;
    logic [CD-1:0] data_o;
    logic          dv_o, line_end_o;

    always #5 clk = ~clk;

    sobel_3x3 #(.COLORDEPTH(CD), .SCREENWIDTH(SW), .SHIFT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tap0_i     (tap0_i),
        .tap1_i     (tap1_i),
        .tap2_i     (tap2_i),
        .dv_i       (dv_i),
        .line_end   (line_end),
        .frame_start(frame_start),
        .data_o     (data_o),
        .dv_o       (dv_o),
        .line_end_o (line_end_o)
    );

    typedef struct { int t0; int t1; int t2; } col_t;
    typedef struct { int val; int cyc; } exp_t;

    col_t win_q[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   m_col    = 0;
    int   m_row    = 0;
    bit   started  = 0;
    bit   rst_seen = 0;
    bit [2:0] le_hist = '0;
    int   last_data = 0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Sobel over the last three valid columns: L oldest, C middle, R newest.
    function automatic int sobel_ref();
        col_t l, c, r;
        int gx, gy, m;
        if (win_q.size() < 3) return 0;
        l = win_q[0]; c = win_q[1]; r = win_q[2];
        gx = (r.t2 + 2 * r.t1 + r.t0) - (l.t2 + 2 * l.t1 + l.t0);
        gy = (l.t0 + 2 * c.t0 + r.t0) - (l.t2 + 2 * c.t2 + r.t2);
        m  = (iabs(gx) + iabs(gy)) / 4;
        return (m > 255) ? 255 : m;
    endfunction

    // Reference model: samples inputs on each active edge.
    always @(posedge clk) begin
        exp_t e;
        col_t cv;
        cyc++;
        started  = 1;
        rst_seen = rst;
        if (rst) begin
            exp_q.delete();
            win_q.delete();
            m_col   = 0;
            m_row   = 0;
            le_hist = '0;
        end else begin
            if (dv_i) begin
                cv.t0 = int'(tap0_i);
                cv.t1 = int'(tap1_i);
                cv.t2 = int'(tap2_i);
                win_q.push_back(cv);
                if (win_q.size() > 3) void'(win_q.pop_front());
                e.cyc = cyc;
                e.val = (m_col < 2 || m_row < 2) ? 0 : sobel_ref();
                exp_q.push_back(e);
            end
            if (line_end) m_col = 0;
            else if (dv_i && m_col < SW) m_col++;
            if (frame_start) m_row = 0;
            else if (line_end && m_row < 2) m_row++;
            le_hist = {le_hist[1:0], line_end};
        end
    end

    // Monitor: compares DUT outputs away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (rst_seen) begin
                checks++;
                if (dv_o !== 1'b0 || data_o !== '0 || line_end_o !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_outs: got dv=%b data=%0d le=%b required 0/0/0",
                             dv_o, data_o, line_end_o);
                end
                last_data = 0;
            end else begin
                checks++;
                if (dv_o === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_dv: got dv_o=1 data=%0d required no output", data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (data_o !== CD'(e.val) || cyc != e.cyc + 2) begin
                            failures++;
                            $display("FAIL pixel: got data=%0d at cycle %0d required data=%0d at cycle %0d",
                                     data_o, cyc, e.val, e.cyc + 2);
                        end
                        last_data = e.val;
                    end
                end else if (dv_o !== 1'b0) begin
                    failures++;
                    $display("FAIL dv_o_x: got dv_o=%b required 0 or 1", dv_o);
                end else if (data_o !== CD'(last_data)) begin
                    failures++;
                    $display("FAIL data_hold: got data=%0d required %0d", data_o, last_data);
                end
                checks++;
                if (line_end_o !== le_hist[2]) begin
                    failures++;
                    $display("FAIL line_end_o: got %b required %b", line_end_o, le_hist[2]);
                end
            end
        end
    end

    task automatic step(input logic r, input logic dv, input logic le, input logic fs,
                        input logic [CD-1:0] a0, input logic [CD-1:0] a1,
                        input logic [CD-1:0] a2);
        rst = r; dv_i = dv; line_end = le; frame_start = fs;
        tap0_i = a0; tap1_i = a1; tap2_i = a2;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0, '0);
    endtask

    // tap: 0 = tap0 (bottom), 1 = tap1, 2 = tap2 (top)
    function automatic logic [CD-1:0] pix(input int mode, input int line, input int col,
                                          input int tap);
        case (mode)
            0: return 8'd100;
            1: return (col < 8) ? 8'd0 : 8'd40;
            2: return (col < 8) ? 8'd0 : 8'd255;
            3: return (col - (2 - tap) >= 6) ? 8'd255 : 8'd0;
            4: return (((col + line + tap) & 1) != 0) ? 8'd255 : 8'd0;
            5: return (tap == 2) ? 8'd0 : 8'd200;
            default: return CD'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_line(input int mode, input int line, input int width,
                             input bit gaps, input bit coinc);
        for (int c = 0; c < width; c++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            step(0, 1, coinc && (c == width - 1), 0,
                 pix(mode, line, c, 0), pix(mode, line, c, 1), pix(mode, line, c, 2));
        end
        if (!coinc) step(0, 0, 1, 0, '0, '0, '0);
        idle();
    endtask

    task automatic frame(input int mode, input int lines, input int width,
                         input bit gaps, input bit coinc);
        step(0, 0, 0, 1, '0, '0, '0);
        for (int l = 0; l < lines; l++) send_line(mode, l, width, gaps, coinc);
    endtask

    initial begin
        rst = 1; dv_i = 0; line_end = 0; frame_start = 0;
        tap0_i = '0; tap1_i = '0; tap2_i = '0;
        repeat (3) step(1, 0, 0, 0, '0, '0, '0);
        idle();

        frame(0, 5, 16, 0, 0);   // flat
        frame(1, 4, 16, 0, 0);   // vertical step 0 -> 40
        frame(2, 4, 16, 0, 1);   // saturating step, line_end on last pixel
        frame(3, 4, 16, 0, 0);   // diagonal corner
        frame(4, 4, 16, 0, 0);   // checkerboard border mask
        frame(5, 4, 16, 1, 0);   // horizontal edge with gaps
        frame(6, 4, 20, 1, 1);   // random with gaps

        // reset mid-line with valids in flight; lines 0-1 masked again after
        frame(6, 3, 12, 0, 0);
        for (int c = 0; c < 5; c++) step(0, 1, 0, 0, 8'd255, 8'd128, 8'd0);
        step(1, 0, 0, 0, '0, '0, '0);
        step(1, 0, 0, 0, '0, '0, '0);
        idle();
        for (int l = 0; l < 4; l++) send_line(6, l, 12, 0, 0);

        // frame_start, line_end and dv_i coincident
        frame(6, 3, 12, 0, 0);
        for (int c = 0; c < 6; c++) step(0, 1, 0, 0, pix(6, 0, c, 0), pix(6, 0, c, 1), pix(6, 0, c, 2));
        step(0, 1, 1, 1, 8'd255, 8'd0, 8'd255);
        for (int l = 0; l < 4; l++) send_line(6, l, 12, 1, 1);

        repeat (8) idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pixels outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
